spi_regbank_bridge: RTL
=======================

Name: spi_regbank_bridge

Overview:
- SPI slave (mode 0, MSB first) that lets an external host read and write the processor register bank over SPI.
- Sits directly upstream of the register bank.
- Drives the bank write port (we/waddr/wdata) and one read port (raddr/rdata).
- All SPI inputs are oversampled in the system clock domain; there is no logic in the sclk domain.

Parameters:
- REG_WIDTH, 32, data width of each register; also the SPI data-phase length in bits.
- REG_COUNT, 16, number of registers in the bank.
- ADDR_WIDTH, $clog2(REG_COUNT), register address width. Derived; do not override.

Ports:
- clk  in  1  system clock
- rst_n  in  1  reset, asynchronous, active-low
- spi_sclk  in  1  SPI clock from host, asynchronous to clk
- spi_cs_n  in  1  SPI chip select, active-low, asynchronous
- spi_mosi  in  1  host-to-slave data, asynchronous
- spi_miso  out  1  slave-to-host data
- rb_we  out  1  bank write enable, one-cycle pulse
- rb_waddr  out  ADDR_WIDTH  bank write address
- rb_wdata  out  REG_WIDTH  bank write data
- rb_raddr  out  ADDR_WIDTH  bank read address
- rb_rdata  in  REG_WIDTH  bank read data, combinational from rb_raddr
- busy  out  1  high while a frame is in progress (state other than IDLE)
- addr_err  out  1  sticky; set on access to address >= REG_COUNT; cleared when the next frame starts

Behaviour:
- Clock and reset: one clock (clk). rst_n is asynchronous assert, active-low.
- Reset values: all outputs 0; state IDLE; shift registers and counters 0.
- Synchronisation: spi_sclk, spi_cs_n and spi_mosi each pass through a 2-flop synchroniser.
- Edge detection: a third flop on sclk detects rising and falling edges. Requirement: f_clk >= 8 * f_sclk.
- Frame format:
  - 8-bit command byte, then REG_WIDTH data bits.
  - cmd[7] = 1 for write, 0 for read.
  - cmd[6:ADDR_WIDTH] reserved and ignored.
  - cmd[ADDR_WIDTH-1:0] = register address.
  - Addresses are checked against REG_COUNT, which covers a non-power-of-2 REG_COUNT.
- Sampling: mosi is sampled on each synchronised sclk rising edge. miso changes on each synchronised falling edge.
- States:
  - IDLE: enter CMD when synchronised cs_n falls; clear addr_err and the bit counter.
  - CMD: shift in 8 bits. On the 8th rising edge, latch the address and go to WR or RD. For a read, drive rb_raddr = addr in the same cycle and load rdata into the tx shift register on the next cycle. The tx register is loaded before the following sclk falling edge, which is guaranteed by the 8x ratio.
  - WR: shift in REG_WIDTH bits. On the last rising edge, the next clk cycle pulses rb_we for exactly 1 cycle with rb_waddr/rb_wdata valid. Then go to DONE. If the address is out of range, suppress rb_we and set addr_err.
  - RD: on each falling edge, spi_miso = tx[MSB] and tx shifts left. After REG_WIDTH bits, go to DONE. If the address is out of range, shift out all zeros and set addr_err.
  - DONE: ignore sclk and hold miso at 0; go to IDLE on cs_n rise.
- Boundary conditions:
  - cs_n rising in any state → IDLE on the next cycle. A partial write is discarded with no rb_we; counters are cleared.
  - spi_miso is 0 whenever not in RD, and 0 during the command phase.
  - rb_waddr/rb_wdata hold their last values between writes. rb_raddr holds the last read address.
  - A sclk edge in the same cycle as the cs_n rise is ignored; cs_n takes priority.
  - Reset asserted mid-frame aborts immediately; the frame is never completed after reset release, and the bridge waits for a fresh cs_n fall.
  - Bit counter width is $clog2(REG_WIDTH+1); no wrap within a frame.

Optional Feature:
- Macro: SPI_BRIDGE_AUTOINC_EN.
- Defined:
  - In WR/RD, if cs_n stays low after REG_WIDTH bits, the address increments and the next REG_WIDTH bits access addr+1 (burst).
  - Address wraps from REG_COUNT-1 to 0.
  - Each word gets its own rb_we pulse; a read reloads tx from the new address.
- Undefined: behaviour exactly as above (DONE after one word).

Test Plan:
- Write 0xDEADBEEF to addr 5 → exactly one rb_we pulse with rb_waddr=5, rb_wdata=0xDEADBEEF, within 2 clk of the 40th sclk rising edge; busy falls after cs_n rises.
- Read addr 3 with rb_rdata model returning 0x12345678 → host captures 0x12345678 on miso over 32 bits; miso=0 during the command byte.
- Write to addr 9 with cs_n released after 20 data bits → no rb_we, state IDLE, busy=0; the next full write to addr 9 succeeds.
- With REG_COUNT=12, write to addr 14 → no rb_we, addr_err=1; a read of addr 14 returns 0x00000000; addr_err clears at the next cs_n fall.
- Assert rst_n low mid-read → all outputs 0 immediately; a frame started afterwards completes correctly.
- With SPI_BRIDGE_AUTOINC_EN defined: burst-write 3 words at addr 15 with REG_COUNT=16 → rb_we pulses at addrs 15, 0, 1 with the matching data.

Source files
------------

// File: rtl/spi_regbank_bridge.sv
// spi_regbank_bridge: SPI mode-0 slave giving an SPI host read/write access to the register bank
// Ports:
//   clk, rst_n          system clock, asynchronous active-low reset
//   spi_sclk/cs_n/mosi  host SPI inputs, asynchronous, oversampled in clk (f_clk >= 8*f_sclk)
//   spi_miso            slave data out, 0 whenever no read data phase is active
//   rb_we/waddr/wdata   bank write port, rb_we is a one-cycle pulse
//   rb_raddr/rb_rdata   bank read port, rb_rdata combinational from rb_raddr
//   busy                frame in progress
//   addr_err            sticky out-of-range access flag, cleared at the next frame start
// Frame: cmd byte {rw, reserved, addr} then REG_WIDTH data bits, MSB first.
// Define SPI_BRIDGE_AUTOINC_EN for burst mode: while cs_n stays low, the address
// increments (wrapping at REG_COUNT) and each further word is a new access.
module spi_regbank_bridge #(
  parameter int REG_WIDTH  = 32,
  parameter int REG_COUNT  = 16,
  parameter int ADDR_WIDTH = $clog2(REG_COUNT)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  spi_sclk,
  input  logic                  spi_cs_n,
  input  logic                  spi_mosi,
  output logic                  spi_miso,
  output logic                  rb_we,
  output logic [ADDR_WIDTH-1:0] rb_waddr,
  output logic [REG_WIDTH-1:0]  rb_wdata,
  output logic [ADDR_WIDTH-1:0] rb_raddr,
  input  logic [REG_WIDTH-1:0]  rb_rdata,
  output logic                  busy,
  output logic                  addr_err
);
  localparam int CW = $clog2(REG_WIDTH + 1);
  localparam logic [ADDR_WIDTH:0] LP_CNT = (ADDR_WIDTH + 1)'(REG_COUNT);
  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_CMD  = 3'd1;
  localparam logic [2:0] S_WR   = 3'd2;
  localparam logic [2:0] S_RD   = 3'd3;
  localparam logic [2:0] S_DONE = 3'd4;
  logic [2:0]            r_sclk;
  logic [2:0]            r_cs;
  logic [1:0]            r_mosi;
  logic [2:0]            r_state;
  logic [CW-1:0]         r_cnt;
  logic [6:0]            r_cmd;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [ADDR_WIDTH-1:0] r_waddr;
  logic [ADDR_WIDTH-1:0] r_raddr;
  logic [REG_WIDTH-2:0]  r_rx;
  logic [REG_WIDTH-1:0]  r_tx;
  logic [REG_WIDTH-1:0]  r_wdata;
  logic                  r_we;
  logic                  r_miso;
  logic                  r_load;
  logic                  r_err;
  logic                  w_rise;
  logic                  w_fall;
  logic                  w_cs_hi;
  logic                  w_cs_fall;
  logic                  w_ok;
  logic                  w_last;
  logic [7:0]            w_cmd;
  logic [REG_WIDTH-1:0]  w_rx;
  // r_sclk[2] is the edge-detect flop behind the two synchroniser stages
  assign w_rise    = r_sclk[1] & ~r_sclk[2];
  assign w_fall    = ~r_sclk[1] & r_sclk[2];
  assign w_cs_hi   = r_cs[1];
  // a true falling edge is needed, so a cs_n held low across reset never restarts a frame
  assign w_cs_fall = r_cs[2] & ~r_cs[1];
  assign w_cmd     = {r_cmd, r_mosi[1]};
  assign w_rx      = {r_rx, r_mosi[1]};
  // widened compare so a non-power-of-2 REG_COUNT is range-checked correctly
  assign w_ok      = {1'b0, r_addr} < LP_CNT;
  assign w_last    = r_cnt == CW'(REG_WIDTH - 1);
`ifdef SPI_BRIDGE_AUTOINC_EN
  logic [ADDR_WIDTH-1:0] w_next_addr;
  assign w_next_addr = (r_addr == ADDR_WIDTH'(REG_COUNT - 1)) ? '0 : r_addr + 1'b1;
`endif
  assign spi_miso  = r_miso & (r_state == S_RD);
  assign rb_we     = r_we;
  assign rb_waddr  = r_waddr;
  assign rb_wdata  = r_wdata;
  assign rb_raddr  = r_raddr;
  assign busy      = r_state != S_IDLE;
  assign addr_err  = r_err;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sclk  <= '0;
      r_cs    <= '0;
      r_mosi  <= '0;
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_cmd   <= '0;
      r_addr  <= '0;
      r_waddr <= '0;
      r_raddr <= '0;
      r_rx    <= '0;
      r_tx    <= '0;
      r_wdata <= '0;
      r_we    <= 1'b0;
      r_miso  <= 1'b0;
      r_load  <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_sclk <= {r_sclk[1:0], spi_sclk};
      r_cs   <= {r_cs[1:0], spi_cs_n};
      r_mosi <= {r_mosi[0], spi_mosi};
      r_we   <= 1'b0;
      // cs_n high aborts any frame and wins over a coincident sclk edge
      if (r_state != S_IDLE && w_cs_hi) begin
        r_state <= S_IDLE;
        r_cnt   <= '0;
        r_load  <= 1'b0;
      end else begin
        case (r_state)
          S_IDLE: if (w_cs_fall) begin
            r_state <= S_CMD;
            r_cnt   <= '0;
            r_err   <= 1'b0;
          end
          S_CMD: if (w_rise) begin
            r_cmd <= w_cmd[6:0];
            r_cnt <= r_cnt + 1'b1;
            if (r_cnt == CW'(7)) begin
              r_addr  <= w_cmd[ADDR_WIDTH-1:0];
              r_cnt   <= '0;
              r_state <= w_cmd[7] ? S_WR : S_RD;
              if (!w_cmd[7]) begin
                r_raddr <= w_cmd[ADDR_WIDTH-1:0];
                r_load  <= 1'b1;
              end
            end
          end
          S_WR: if (w_rise) begin
            r_rx  <= w_rx[REG_WIDTH-2:0];
            r_cnt <= r_cnt + 1'b1;
            if (w_last) begin
              r_we  <= w_ok;
              r_err <= r_err | ~w_ok;
              r_cnt <= '0;
              if (w_ok) begin
                r_waddr <= r_addr;
                r_wdata <= w_rx;
              end
`ifdef SPI_BRIDGE_AUTOINC_EN
              r_addr <= w_next_addr;
`else
              r_state <= S_DONE;
`endif
            end
          end
          S_RD: begin
            // rb_raddr settled last cycle, so rb_rdata is valid now
            if (r_load) begin
              r_tx   <= w_ok ? rb_rdata : '0;
              r_err  <= r_err | ~w_ok;
              r_miso <= 1'b0;
              r_load <= 1'b0;
            end else if (w_fall) begin
              r_miso <= r_tx[REG_WIDTH-1];
              r_tx   <= {r_tx[REG_WIDTH-2:0], 1'b0};
            end
            // word ends on the host's last sampling edge so the final bit is held until then
            if (w_rise) begin
              r_cnt <= r_cnt + 1'b1;
              if (w_last) begin
                r_cnt <= '0;
`ifdef SPI_BRIDGE_AUTOINC_EN
                r_addr  <= w_next_addr;
                r_raddr <= w_next_addr;
                r_load  <= 1'b1;
`else
                r_state <= S_DONE;
`endif
              end
            end
          end
          default: ;
        endcase
      end
    end
  end
endmodule
